// File: rtl/fetch_unit.sv
// Two-word instruction fetch: reads the two 16-bit halves named by instr_pointer,
// then holds the assembled instruction on a valid/ready handshake toward decode.
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0001
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] next_pointer,
    output logic [31:0] instr_pointer,
    output logic        mem_req,
    output logic [15:0] mem_addr,
    input  logic        mem_ack,
    input  logic [15:0] mem_rdata,
    output logic [31:0] instruction,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic        busy
);

    typedef enum logic [1:0] {
        FETCH0 = 2'd0,
        FETCH1 = 2'd1,
        ISSUE  = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] instr_pointer_q, instr_pointer_d;
    logic [31:0] instruction_q, instruction_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q         <= FETCH0;
            instr_pointer_q <= RESET_PC;
            instruction_q   <= 32'h0;
        end else begin
            state_q         <= state_d;
            instr_pointer_q <= instr_pointer_d;
            instruction_q   <= instruction_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            FETCH0:  if (mem_ack)     state_d = FETCH1;
            FETCH1:  if (mem_ack)     state_d = ISSUE;
            ISSUE:   if (instr_ready) state_d = FETCH0;
            default:                  state_d = FETCH0;
        endcase
    end

    // mem_ack only matters in the fetch states, so ISSUE never captures stray data.
    always_comb begin
        instruction_d   = instruction_q;
        instr_pointer_d = instr_pointer_q;
        case (state_q)
            FETCH0:  if (mem_ack)     instruction_d[31:16] = mem_rdata;
            FETCH1:  if (mem_ack)     instruction_d[15:0]  = mem_rdata;
            ISSUE:   if (instr_ready) instr_pointer_d      = next_pointer;
            default: ;
        endcase
    end

    always_comb begin
        mem_req     = 1'b0;
        mem_addr    = instr_pointer_q[31:16];
        instr_valid = 1'b0;
        busy        = 1'b0;
        case (state_q)
            FETCH0: begin
                mem_req  = 1'b1;
                mem_addr = instr_pointer_q[31:16];
                busy     = 1'b1;
            end
            FETCH1: begin
                mem_req  = 1'b1;
                mem_addr = instr_pointer_q[15:0];
                busy     = 1'b1;
            end
            ISSUE:   instr_valid = 1'b1;
            default: ;
        endcase
    end

    assign instr_pointer = instr_pointer_q;
    assign instruction   = instruction_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: transaction-level model compared every cycle, plus
// directed scenarios with hand-computed literal expectations.
module tb_fetch_unit;

    localparam logic [31:0] RESET_PC = 32'h0000_0001;

    logic        clk;
    logic        rst;
    logic [31:0] next_pointer;
    logic [31:0] instr_pointer;
    logic        mem_req;
    logic [15:0] mem_addr;
    logic        mem_ack;
    logic [15:0] mem_rdata;
    logic [31:0] instruction;
    logic        instr_valid;
    logic        instr_ready;
    logic        busy;

    int total = 0;
    int bad   = 0;
    bit cmp_en = 0;

    fetch_unit #(.RESET_PC(RESET_PC)) dut (
        .clk          (clk),
        .rst          (rst),
        .next_pointer (next_pointer),
        .instr_pointer(instr_pointer),
        .mem_req      (mem_req),
        .mem_addr     (mem_addr),
        .mem_ack      (mem_ack),
        .mem_rdata    (mem_rdata),
        .instruction  (instruction),
        .instr_valid  (instr_valid),
        .instr_ready  (instr_ready),
        .busy         (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory contents: words 0/1 are fixed, everything else is addr ^ A5C3.
    function automatic logic [15:0] mem_word(input logic [15:0] a);
        case (a)
            16'h0000: return 16'h4123;
            16'h0001: return 16'hBEEF;
            default:  return a ^ 16'hA5C3;
        endcase
    endfunction

    assign mem_rdata = mem_req ? mem_word(mem_addr) : 16'hDEAD;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Model: how many halves of the current instruction have been fetched (0..2).
    int          m_words;
    logic [31:0] m_ptr;
    logic [31:0] m_instr;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_words <= 0;
            m_ptr   <= RESET_PC;
            m_instr <= 32'h0;
        end else if (m_words == 0) begin
            if (mem_ack) begin
                m_instr[31:16] <= mem_word(m_ptr[31:16]);
                m_words        <= 1;
            end
        end else if (m_words == 1) begin
            if (mem_ack) begin
                m_instr[15:0] <= mem_word(m_ptr[15:0]);
                m_words       <= 2;
            end
        end else if (instr_ready) begin
            m_ptr   <= next_pointer;
            m_words <= 0;
        end
    end

    always @(posedge clk) begin
        #1;
        if (cmp_en) begin
            check("cyc_mem_req", {31'd0, mem_req}, {31'd0, m_words < 2});
            check("cyc_busy", {31'd0, busy}, {31'd0, m_words < 2});
            check("cyc_valid", {31'd0, instr_valid}, {31'd0, m_words == 2});
            check("cyc_pointer", instr_pointer, m_ptr);
            check("cyc_instr", instruction, m_instr);
            if (m_words < 2)
                check("cyc_addr", {16'd0, mem_addr},
                      {16'd0, (m_words == 0) ? m_ptr[31:16] : m_ptr[15:0]});
        end
    end

    task automatic wait_valid(input int max);
        int n = 0;
        while (instr_valid !== 1'b1 && n < max) begin
            @(negedge clk);
            n++;
        end
        check("wait_valid", {31'd0, instr_valid}, 32'd1);
    endtask

    initial begin
        rst          = 1'b1;
        mem_ack      = 1'b1;
        instr_ready  = 1'b1;
        next_pointer = 32'h0002_0003;
        repeat (2) @(negedge clk);
        #1;
        check("rst_pointer", instr_pointer, RESET_PC);
        check("rst_instr", instruction, 32'h0);
        check("rst_valid", {31'd0, instr_valid}, 32'd0);

        // Basic fetch of words 0 and 1
        rst    = 1'b0;
        cmp_en = 1'b1;
        #1;
        check("first_req", {31'd0, mem_req}, 32'd1);
        check("first_addr", {16'd0, mem_addr}, 32'h0000);
        check("first_busy", {31'd0, busy}, 32'd1);
        @(posedge clk); #2;
        check("second_addr", {16'd0, mem_addr}, 32'h0001);
        @(posedge clk); #2;
        check("issue_valid", {31'd0, instr_valid}, 32'd1);
        check("issue_instr", instruction, 32'h4123_BEEF);
        @(negedge clk);
        @(negedge clk); #1;
        check("load_pointer", instr_pointer, 32'h0002_0003);
        check("load_addr", {16'd0, mem_addr}, 32'h0002);

        // Hold in ISSUE while next_pointer toggles
        wait_valid(10);
        instr_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            next_pointer = i[0] ? 32'hDEAD_BEEF : 32'h1234_5678;
            @(negedge clk); #1;
            check("hold_instr", instruction, 32'hA5C1_A5C0);
            check("hold_pointer", instr_pointer, 32'h0002_0003);
        end
        next_pointer = 32'h0010_0011;
        instr_ready  = 1'b1;
        @(negedge clk); #1;
        check("ready_pointer", instr_pointer, 32'h0010_0011);
        check("ready_addr", {16'd0, mem_addr}, 32'h0010);

        // Stall FETCH1 for four cycles
        @(negedge clk);
        mem_ack = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk); #1;
            check("stall_req", {31'd0, mem_req}, 32'd1);
            check("stall_addr", {16'd0, mem_addr}, 32'h0011);
            check("stall_valid", {31'd0, instr_valid}, 32'd0);
        end
        mem_ack = 1'b1;
        @(negedge clk); #1;
        check("stall_done_valid", {31'd0, instr_valid}, 32'd1);
        check("stall_done_instr", instruction, 32'hA5D3_A5D2);

        // ack held high in ISSUE without ready
        instr_ready = 1'b0;
        repeat (3) begin
            @(negedge clk); #1;
            check("issue_ack_instr", instruction, 32'hA5D3_A5D2);
        end

        // Pointer wrap supplied by next_pointer
        next_pointer = 32'hFFFF_0000;
        instr_ready  = 1'b1;
        @(negedge clk); #1;
        check("wrap_addr0", {16'd0, mem_addr}, 32'hFFFF);
        @(negedge clk); #1;
        check("wrap_addr1", {16'd0, mem_addr}, 32'h0000);

        // Reset in FETCH1 after word0 was captured
        rst = 1'b1;
        #1;
        check("abort_instr", instruction, 32'h0);
        check("abort_pointer", instr_pointer, RESET_PC);
        check("abort_valid", {31'd0, instr_valid}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("restart_addr", {16'd0, mem_addr}, 32'h0000);
        check("restart_valid", {31'd0, instr_valid}, 32'd0);
        wait_valid(10);
        check("restart_instr", instruction, 32'h4123_BEEF);

        // Equal halves: same address read twice
        next_pointer = 32'h0005_0005;
        @(negedge clk); #1;
        check("equal_addr0", {16'd0, mem_addr}, 32'h0005);
        @(negedge clk); #1;
        check("equal_addr1", {16'd0, mem_addr}, 32'h0005);
        @(negedge clk); #1;
        check("equal_instr", instruction, 32'hA5C6_A5C6);

        instr_ready = 1'b0;
        repeat (2) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0001, gives the instr_pointer value loaded at reset: pointer0=16'h0000, pointer1=16'h0001.
REQ-002 clk  input  1  single clock; all state changes on its rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 next_pointer  input  32  {pointer0,pointer1} computed by the branch/counter stage from instr_pointer and the issued instruction.
REQ-005 instr_pointer  output  32  current {pointer0,pointer1}, registered, fed to the branch/counter stage.
REQ-006 mem_req  output  1  instruction-memory read request.
REQ-007 mem_addr  output  16  16-bit word address of the pending read.
REQ-008 mem_ack  input  1  memory accepts the request and returns data this cycle.
REQ-009 mem_rdata  input  16  read data, valid only when mem_req && mem_ack.
REQ-010 instruction  output  32  assembled instruction {word0,word1}, registered.
REQ-011 instr_valid  output  1  instruction is valid toward decode/execute.
REQ-012 instr_ready  input  1  downstream consumes instruction this cycle.
REQ-013 busy  output  1  high in the FETCH0 and FETCH1 states.

Function
REQ-014 The FSM SHALL have three states: FETCH0, FETCH1 and ISSUE. Encoding is free.
REQ-015 FETCH0 SHALL drive mem_req=1 and mem_addr=instr_pointer[31:16].
  - On mem_ack: capture mem_rdata into instruction[31:16], then go to FETCH1.
REQ-016 FETCH1 SHALL drive mem_req=1 and mem_addr=instr_pointer[15:0].
  - On mem_ack: capture mem_rdata into instruction[15:0], then go to ISSUE.
REQ-017 In FETCH0 and FETCH1, while mem_ack=0, the unit SHALL hold mem_req=1, hold mem_addr stable and leave state unchanged; there is no timeout.
REQ-018 ISSUE SHALL drive instr_valid=1 and mem_req=0.
  - On instr_ready: load instr_pointer<=next_pointer, then go to FETCH0.
  - Otherwise: hold instruction, instr_pointer and instr_valid unchanged.
REQ-019 instr_valid SHALL be 0 in FETCH0 and FETCH1, and instr_ready SHALL be ignored in those states.
REQ-020 mem_ack SHALL be ignored whenever mem_req=0, including in ISSUE.
REQ-021 instr_pointer SHALL change only on an ISSUE-state handshake (instr_valid && instr_ready).
  - The change SHALL be a full 32-bit load of next_pointer, with no arithmetic in this block.
  - Wrap-around 16'hFFFF->16'h0000 is therefore whatever next_pointer supplies.
REQ-022 instruction SHALL stay constant from entry into ISSUE until the handshake.
REQ-023 Minimum latency SHALL be 3 cycles per instruction with mem_ack tied high and instr_ready tied high: FETCH0, FETCH1, ISSUE.
REQ-024 The unit SHALL support equal halves (instr_pointer[31:16]==instr_pointer[15:0]): it issues two reads of the same address.
REQ-025 mem_req, mem_addr, instr_valid and busy SHALL be decoded from registered state only, so they have no combinational path from any input.

Reset
REQ-026 While rst=1, asynchronously and independent of clk, the unit SHALL set: state=FETCH0, instr_pointer=RESET_PC, instruction=32'h0, instr_valid=0.
REQ-027 After release and on the first clk edge, mem_req=1 with mem_addr=RESET_PC[31:16] and busy=1.
REQ-028 Reset asserted mid-fetch or in ISSUE SHALL abandon the transaction and clear state as in REQ-026.
  - mem_req SHALL drop combinationally with state.
  - No partial instruction SHALL be issued afterwards.

Verification
REQ-029 Reset release, mem_ack=1, instr_ready=1, mem word[0]=16'h4123, word[1]=16'hBEEF -> mem_addr 0 then 1; instruction=32'h4123BEEF with instr_valid=1 on the 3rd cycle.
REQ-030 mem_ack held 0 for 4 cycles in FETCH1 -> mem_req=1 and mem_addr constant for all 4 cycles; instr_valid=0; capture occurs only on the cycle ack rises.
REQ-031 In ISSUE, instr_ready=0 for 5 cycles while next_pointer toggles -> instruction and instr_pointer unchanged; on ready, instr_pointer=next_pointer sampled that cycle, e.g. 32'h0010_0011 -> next reads at addresses 16'h0010 and 16'h0011.
REQ-032 next_pointer=32'hFFFF_0000 at handshake -> next fetches at addresses 16'hFFFF then 16'h0000.
REQ-033 rst pulse in FETCH1 after word0 captured -> instruction=0, instr_pointer=RESET_PC, fetch restarts at RESET_PC[31:16], and no instr_valid pulse from the aborted fetch.
REQ-034 mem_ack=1 held in ISSUE with instr_ready=0 -> no capture, instruction unchanged.
